// File: rtl/trdb_branch_unpacker.sv
// Branch-map unpacker: holds one branch map in service and one skid map, and
// returns one taken/not-taken outcome per pop, oldest branch first.
//
// state         | meaning
// ST_EMPTY      | no outcomes held; active and skid slots both free
// ST_SERVE      | active slot holds outcomes, skid slot free
// ST_SERVE_SKID | active slot holds outcomes, skid slot holds the next map
module trdb_branch_unpacker #(
   parameter int unsigned MAP_LEN = 31,
   parameter int unsigned CNT_W   = 5
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   input  logic               load_valid_i,
   output logic               load_ready_o,
   input  logic [MAP_LEN-1:0] map_i,
   input  logic [CNT_W-1:0]   branches_i,
   input  logic               pop_i,
   output logic               taken_valid_o,
   output logic               taken_o,
   output logic [CNT_W-1:0]   remaining_o,
   output logic               empty_o,
   output logic               underflow_o,
   output logic               len_err_o
);

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_SERVE,
      ST_SERVE_SKID
   } slot_state_e;

   localparam logic [CNT_W:0] MAX_CNT = (CNT_W+1)'(MAP_LEN);

   slot_state_e        state_q, state_d;
   logic [MAP_LEN-1:0] act_map_q, act_map_d;
   logic [CNT_W-1:0]   act_cnt_q, act_cnt_d;
   logic [MAP_LEN-1:0] skid_map_q, skid_map_d;
   logic [CNT_W-1:0]   skid_cnt_q, skid_cnt_d;
   logic               underflow_q, underflow_d;
   logic               len_err_q, len_err_d;

   logic               skid_full;
   logic               skid_full_d;
   logic               pop_ok;
   logic               load_fire;
   logic               over_len;
   logic [CNT_W-1:0]   load_cnt;
   logic [MAP_LEN-1:0] load_map;

   assign skid_full = (state_q == ST_SERVE_SKID);

   always_comb begin
      pop_ok    = pop_i && (act_cnt_q != '0);
      load_fire = load_valid_i && !skid_full && !flush_i;
      over_len  = ({1'b0, branches_i} > MAX_CNT);
      load_cnt  = over_len ? MAX_CNT[CNT_W-1:0] : branches_i;
      // bits beyond the branch count are cleared so stale bits never reach taken_o
      load_map  = '0;
      for (int k = 0; k < int'(MAP_LEN); k++) begin
         load_map[k] = map_i[k] & (k < int'(load_cnt));
      end
   end

   always_comb begin
      state_d     = state_q;
      act_map_d   = act_map_q;
      act_cnt_d   = act_cnt_q;
      skid_map_d  = skid_map_q;
      skid_cnt_d  = skid_cnt_q;
      underflow_d = underflow_q;
      len_err_d   = 1'b0;
      skid_full_d = skid_full;

      if (flush_i) begin
         state_d     = ST_EMPTY;
         act_map_d   = '0;
         act_cnt_d   = '0;
         skid_map_d  = '0;
         skid_cnt_d  = '0;
         underflow_d = 1'b0;
         skid_full_d = 1'b0;
      end else begin
         if (pop_i && !pop_ok) begin
            underflow_d = 1'b1;
         end
         if (pop_ok) begin
            act_map_d = act_map_q >> 1;
            act_cnt_d = act_cnt_q - CNT_W'(1);
         end
         // skid promotes on the same edge the last active outcome leaves
         if ((act_cnt_d == '0) && skid_full) begin
            act_map_d   = skid_map_q;
            act_cnt_d   = skid_cnt_q;
            skid_map_d  = '0;
            skid_cnt_d  = '0;
            skid_full_d = 1'b0;
         end
         if (load_fire) begin
            len_err_d = over_len;
            if (load_cnt != '0) begin
               if (act_cnt_d == '0) begin
                  act_map_d = load_map;
                  act_cnt_d = load_cnt;
               end else begin
                  skid_map_d  = load_map;
                  skid_cnt_d  = load_cnt;
                  skid_full_d = 1'b1;
               end
            end
         end

         if (act_cnt_d == '0) begin
            state_d = ST_EMPTY;
         end else if (skid_full_d) begin
            state_d = ST_SERVE_SKID;
         end else begin
            state_d = ST_SERVE;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_EMPTY;
         act_map_q   <= '0;
         act_cnt_q   <= '0;
         skid_map_q  <= '0;
         skid_cnt_q  <= '0;
         underflow_q <= 1'b0;
         len_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         act_map_q   <= act_map_d;
         act_cnt_q   <= act_cnt_d;
         skid_map_q  <= skid_map_d;
         skid_cnt_q  <= skid_cnt_d;
         underflow_q <= underflow_d;
         len_err_q   <= len_err_d;
      end
   end

   // flush forces ready high even with the skid full; the load is still dropped
   assign load_ready_o  = flush_i || !skid_full;
   assign taken_valid_o = (act_cnt_q != '0);
   assign taken_o       = taken_valid_o & act_map_q[0];
   assign remaining_o   = act_cnt_q;
   assign empty_o       = (act_cnt_q == '0) && !skid_full;
   assign underflow_o   = underflow_q;
   assign len_err_o     = len_err_q;

endmodule

// File: tb/tb_trdb_branch_unpacker.sv
// Scoreboard bench for trdb_branch_unpacker: a queue-of-bits reference model
// produces expected status and outcomes; a negedge monitor compares them.
module tb_trdb_branch_unpacker;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        flush_i = 1'b0;
   logic        load_valid_i = 1'b0;
   logic        load_ready_o;
   logic [30:0] map_i = '0;
   logic [4:0]  branches_i = '0;
   logic        pop_i = 1'b0;
   logic        taken_valid_o;
   logic        taken_o;
   logic [4:0]  remaining_o;
   logic        empty_o;
   logic        underflow_o;
   logic        len_err_o;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit ready;
      bit tv;
      bit tk;
      int rem;
      bit empty;
      bit uf;
      bit le;
   } status_t;

   status_t status_q[$];
   bit      outcome_q[$];

   // reference model: outcomes as plain bit queues, oldest first
   bit m_act[$];
   bit m_skid[$];
   bit m_uf = 1'b0;
   bit m_le = 1'b0;

   trdb_branch_unpacker #(.MAP_LEN(31), .CNT_W(5)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .flush_i      (flush_i),
      .load_valid_i (load_valid_i),
      .load_ready_o (load_ready_o),
      .map_i        (map_i),
      .branches_i   (branches_i),
      .pop_i        (pop_i),
      .taken_valid_o(taken_valid_o),
      .taken_o      (taken_o),
      .remaining_o  (remaining_o),
      .empty_o      (empty_o),
      .underflow_o  (underflow_o),
      .len_err_o    (len_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " load_ready"}, load_ready_o, 1);
      chk({tag, " taken_valid"}, taken_valid_o, 0);
      chk({tag, " taken"}, taken_o, 0);
      chk({tag, " remaining"}, remaining_o, 0);
      chk({tag, " empty"}, empty_o, 1);
      chk({tag, " underflow"}, underflow_o, 0);
      chk({tag, " len_err"}, len_err_o, 0);
   endtask

   // one clock cycle of stimulus: record expectations, then advance the model
   task automatic cycle(input bit fl, input bit lv, input logic [30:0] mp,
                        input int br, input bit pp);
      status_t s;
      bit      acc;
      int      n;
      bit      bits[$];
      @(posedge clk_i);
      #2;
      flush_i      = fl;
      load_valid_i = lv;
      map_i        = mp;
      branches_i   = br[4:0];
      pop_i        = pp;

      s.ready = fl || (m_skid.size() == 0);
      s.tv    = (m_act.size() > 0);
      s.tk    = s.tv ? m_act[0] : 1'b0;
      s.rem   = m_act.size();
      s.empty = (m_act.size() == 0) && (m_skid.size() == 0);
      s.uf    = m_uf;
      s.le    = m_le;
      status_q.push_back(s);
      if (pp && m_act.size() > 0) outcome_q.push_back(m_act[0]);

      if (fl) begin
         m_act.delete();
         m_skid.delete();
         m_uf = 1'b0;
         m_le = 1'b0;
      end else begin
         acc  = lv && (m_skid.size() == 0);
         n    = (br > 31) ? 31 : br;
         m_le = acc && (br > 31);
         if (pp) begin
            if (m_act.size() > 0) void'(m_act.pop_front());
            else m_uf = 1'b1;
         end
         if (m_act.size() == 0 && m_skid.size() > 0) begin
            m_act = m_skid;
            m_skid.delete();
         end
         if (acc && n > 0) begin
            for (int k = 0; k < n; k++) bits.push_back(mp[k]);
            if (m_act.size() == 0) m_act = bits;
            else m_skid = bits;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, 0);
   endtask

   task automatic pops(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, 1);
   endtask

   task automatic async_reset();
      @(negedge clk_i);
      #1;
      flush_i      = 1'b0;
      load_valid_i = 1'b0;
      pop_i        = 1'b0;
      rst_i        = 1'b1;
      #1;
      chk_reset_outputs("async_rst");
      m_act.delete();
      m_skid.delete();
      m_uf = 1'b0;
      m_le = 1'b0;
      status_q.delete();
      outcome_q.delete();
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   initial begin : monitor
      status_t s;
      bit      e;
      forever begin
         @(negedge clk_i);
         if (!rst_i && status_q.size() > 0) begin
            s = status_q.pop_front();
            chk("load_ready", load_ready_o, s.ready);
            chk("taken_valid", taken_valid_o, s.tv);
            chk("taken", taken_o, s.tk);
            chk("remaining", remaining_o, s.rem);
            chk("empty", empty_o, s.empty);
            chk("underflow", underflow_o, s.uf);
            chk("len_err", len_err_o, s.le);
            if (pop_i && taken_valid_o) begin
               if (outcome_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL outcome: DUT popped %0d but no outcome expected", taken_o);
               end else begin
                  e = outcome_q.pop_front();
                  chk("outcome", taken_o, e);
               end
            end
         end
      end
   end

   initial begin : stimulus
      #12;
      chk_reset_outputs("reset");
      @(negedge clk_i);
      rst_i = 1'b0;

      // single map, pops 1,1,0,1 then empty
      cycle(0, 1, 31'b1011, 4, 0);
      pops(4);
      idle(2);

      // back-to-back A then B into skid, zero-bubble handoff
      cycle(0, 1, 31'b10, 2, 0);
      cycle(0, 1, 31'b111, 3, 0);
      pops(5);
      idle(2);

      // last pop of A with simultaneous load of C
      cycle(0, 1, 31'b10, 2, 0);
      pops(1);
      cycle(0, 1, 31'b0110101, 7, 1);
      pops(7);
      idle(1);

      // underflow sticky, cleared by flush
      pops(1);
      idle(2);
      cycle(1, 0, '0, 0, 0);
      idle(1);

      // zero-length map, then full-length all-ones
      cycle(0, 1, 31'h7FFF_FFFF, 0, 0);
      idle(1);
      cycle(0, 1, 31'h7FFF_FFFF, 31, 0);
      pops(31);
      idle(2);

      // flush with skid full plus a load and a pop, then async reset mid-map
      cycle(0, 1, 31'b10110, 5, 0);
      cycle(0, 1, 31'b1001, 4, 0);
      cycle(1, 1, 31'b111111, 6, 1);
      idle(2);
      cycle(0, 1, 31'hA5, 8, 0);
      pops(2);
      async_reset();
      idle(2);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) async_reset();
         cycle($urandom_range(0, 99) < 2,
               $urandom_range(0, 9) < 4,
               31'($urandom),
               $urandom_range(0, 31),
               $urandom_range(0, 9) < 6);
      end
      idle(3);
      @(negedge clk_i);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
